// File: rtl/key_pulse_multi.sv
// Multi-channel push-button conditioner: 2-flop sync, counter debounce and press FSM per key.
// Optional auto-repeat on held keys is compiled in with `define KEY_AUTOREPEAT_EN (EDGE_MODE=1 only).
module key_pulse_multi #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EDGE_MODE       = 0,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] pulse,
  output logic [N_KEYS-1:0] held,
  output logic              any_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {UNPRESSED, PRESSED} state_t;

  if (N_KEYS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("key_pulse_multi: parameters must all be >= 1");
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    state_t        state;
    logic          held_r;
    logic          pulse_r;
    logic          flip;
    logic          flip_pulse;
    logic          rpt_pulse;

    assign flip       = (s2 != held_r) && (cnt == CNT_LAST);
    assign flip_pulse = flip && ((EDGE_MODE != 0) ? s2 : !s2);

`ifdef KEY_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RPT_DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt;
    logic          rpt_on;
    logic          rpt_hit;

    assign rpt_hit = (state == PRESSED) && !flip &&
                     (rpt == (rpt_on ? RPT_PER_LAST : RPT_DLY_LAST));
    // Repeats also require the synchronised key still down, so they stop as
    // soon as the release reaches s2 rather than after it is debounced.
    assign rpt_pulse = (EDGE_MODE != 0) && rpt_hit && s2;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rpt    <= '0;
        rpt_on <= 1'b0;
      end else if (flip || state != PRESSED) begin
        rpt    <= '0;
        rpt_on <= 1'b0;
      end else if (rpt_hit) begin
        rpt    <= '0;
        rpt_on <= 1'b1;
      end else begin
        rpt    <= rpt + 1'b1;
      end
    end
`else
    assign rpt_pulse = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1      <= 1'b0;
        s2      <= 1'b0;
        cnt     <= '0;
        state   <= UNPRESSED;
        held_r  <= 1'b0;
        pulse_r <= 1'b0;
      end else begin
        s1      <= key[g];
        s2      <= s1;
        pulse_r <= flip_pulse | rpt_pulse;
        if (s2 == held_r) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt    <= '0;
          held_r <= s2;
          case (state)
            UNPRESSED: if (s2)  state <= PRESSED;
            PRESSED:   if (!s2) state <= UNPRESSED;
            default:            state <= UNPRESSED;
          endcase
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign held[g]  = held_r;
    assign pulse[g] = pulse_r;
  end

  assign any_pulse = |pulse;

endmodule

// File: tb/tb_key_pulse_multi.sv
// Scoreboard bench for key_pulse_multi: one release-mode and one press-mode instance on shared keys.
module tb_key_pulse_multi;

`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic [3:0] pulse_rel, held_rel, pulse_prs, held_prs;
  logic       any_rel, any_prs;

  always #5 clk = ~clk;

  key_pulse_multi #(.N_KEYS(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0),
                    .REPEAT_DELAY(16), .REPEAT_PERIOD(8)) u_rel (
    .clk(clk), .rst(rst), .key(key),
    .pulse(pulse_rel), .held(held_rel), .any_pulse(any_rel)
  );

  key_pulse_multi #(.N_KEYS(4), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1),
                    .REPEAT_DELAY(16), .REPEAT_PERIOD(8)) u_prs (
    .clk(clk), .rst(rst), .key(key),
    .pulse(pulse_prs), .held(held_prs), .any_pulse(any_prs)
  );

  typedef struct {
    string      tag;
    logic [3:0] held;
    logic [3:0] p_rel;
    logic [3:0] p_prs;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] prev_held = '0;

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge outputs, then compare.
  task automatic step(input string tag, input logic [3:0] k, input logic [3:0] eh,
                      input logic [3:0] rpt);
    exp_t e;
    key     = k;
    e.tag   = tag;
    e.held  = eh;
    e.p_rel = prev_held & ~eh;
    e.p_prs = (~prev_held & eh) | rpt;
    sb.push_back(e);
    prev_held = eh;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq({e.tag, "/held_rel"},  held_rel,  e.held);
    check_eq({e.tag, "/held_prs"},  held_prs,  e.held);
    check_eq({e.tag, "/pulse_rel"}, pulse_rel, e.p_rel);
    check_eq({e.tag, "/pulse_prs"}, pulse_prs, e.p_prs);
    check_eq({e.tag, "/any_rel"},   {3'b000, any_rel}, {3'b000, |e.p_rel});
    check_eq({e.tag, "/any_prs"},   {3'b000, any_prs}, {3'b000, |e.p_prs});
  endtask

  task automatic check_cleared(input string tag);
    check_eq({tag, "/held_rel"},  held_rel,  4'b0000);
    check_eq({tag, "/held_prs"},  held_prs,  4'b0000);
    check_eq({tag, "/pulse_rel"}, pulse_rel, 4'b0000);
    check_eq({tag, "/pulse_prs"}, pulse_prs, 4'b0000);
    check_eq({tag, "/any_prs"},   {3'b000, any_prs}, 4'b0000);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    key = '0;
    #1;
    rst = 1'b1;
    key = 4'b1111;
    #1;
    check_cleared("rst_async");

    // keys all down while in reset, then held through release
    for (int j = 0; j < 3; j++) step("rst_hold", 4'b1111, 4'b0000, 4'b0000);
    rst = 1'b0;
    for (int j = 0; j < 16; j++)
      step("rst_release", (j < 8) ? 4'b1111 : 4'b0000,
           (j >= 5 && j < 13) ? 4'b1111 : 4'b0000, 4'b0000);

    // single key press/release with latency D+1 on both edges
    for (int j = 0; j < 18; j++)
      step("key0_press", (j < 10) ? 4'b0001 : 4'b0000,
           (j >= 5 && j < 15) ? 4'b0001 : 4'b0000, 4'b0000);

    // bouncing key: 3-high / 2-low runs never debounce
    for (int j = 0; j < 20; j++)
      step("key1_bounce", (j % 5 < 3) ? 4'b0010 : 4'b0000, 4'b0000, 4'b0000);
    for (int j = 0; j < 6; j++) step("key1_settle", 4'b0000, 4'b0000, 4'b0000);

    // simultaneous flips on two channels
    for (int j = 0; j < 16; j++)
      step("key23_simul", (j < 8) ? 4'b1100 : 4'b0000,
           (j >= 5 && j < 13) ? 4'b1100 : 4'b0000, 4'b0000);

    // reset while key0 pressed, on the cycle its press pulse is showing
    for (int j = 0; j < 6; j++)
      step("key0_pre_rst", 4'b0001, (j >= 5) ? 4'b0001 : 4'b0000, 4'b0000);
    rst = 1'b1;
    #1;
    check_cleared("mid_rst_async");
    prev_held = '0;
    step("mid_rst_hold", 4'b0001, 4'b0000, 4'b0000);
    rst = 1'b0;

    // key held through reset release, then long hold (auto-repeat when compiled in)
    for (int j = 0; j < 59; j++)
      step("key0_long", (j < 50) ? 4'b0001 : 4'b0000,
           (j >= 5 && j < 55) ? 4'b0001 : 4'b0000,
           (AR && (j == 21 || j == 29 || j == 37 || j == 45)) ? 4'b0001 : 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
